// File: rtl/mmio_out_fifo_bank.sv
// Memory-mapped bank of NUM_CH output channels on the picorv32 native memory bus.
// Each channel has a DATA push register, a STATUS register, a FIFO and a ready/valid stream.
module mmio_out_fifo_bank #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          NUM_CH     = 4,
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter bit          BLOCKING   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready
);
    localparam int              PW        = $clog2(FIFO_DEPTH);
    localparam int              LW        = PW + 1;
    localparam int              CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0]     WIN_BYTES = 32'(8 * NUM_CH);
    localparam logic [LW-1:0]   DEPTH_L   = LW'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_ACK} state_t;
    state_t state, state_nx;

    logic [31:0]       offset;
    logic              hit, is_write, sel_status, idle, data_wr, stall, access;
    logic [CW-1:0]     ch;
    logic [NUM_CH-1:0] ch_sel, full, pop, push_req, push, ovf, ovf_set, ovf_clr;
    logic [31:0]       status_rd, rdata_nx;
    logic              unused_wdata;

    logic [DATA_W-1:0] fifo_mem [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr   [NUM_CH];
    logic [PW-1:0]     wr_ptr   [NUM_CH];
    logic [LW-1:0]     level    [NUM_CH];

    // Addresses below BASE_ADDR wrap to large offsets, so one unsigned compare bounds the window.
    assign offset       = mem_addr - BASE_ADDR;
    assign hit          = mem_valid && (offset < WIN_BYTES);
    assign is_write     = |mem_wstrb;
    assign sel_status   = offset[2];
    assign ch           = offset[3 +: CW];
    assign idle         = (state == S_IDLE);
    assign data_wr      = hit && idle && is_write && !sel_status && mem_wstrb[0];
    assign unused_wdata = ^mem_wdata;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        status_rd = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sel[c] = (ch == CW'(c));
            full[c]   = (level[c] == DEPTH_L);
            pop[c]    = (level[c] != '0) && out_ready[c];
            if (ch_sel[c]) begin
                status_rd = {8'h00, 8'(level[c]), 7'h00, ovf[c], 6'h00, full[c], level[c] == '0};
            end
        end
    end

    // A blocking push to a full FIFO waits in IDLE unless a pop frees the slot this same cycle.
    assign stall  = BLOCKING && data_wr && |(ch_sel & full & ~pop);
    assign access = hit && idle && !stall;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            push_req[c] = access && data_wr && ch_sel[c];
            push[c]     = push_req[c] && (!full[c] || pop[c]);
            ovf_set[c]  = push_req[c] && full[c] && !pop[c];
            ovf_clr[c]  = access && is_write && sel_status && mem_wstrb[1] && mem_wdata[8] && ch_sel[c];
        end
    end

    assign rdata_nx = (access && !is_write && sel_status) ? status_rd : 32'h0;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (access) state_nx = S_ACK;
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_rdata <= '0;
        end else begin
            state     <= state_nx;
            mem_rdata <= rdata_nx;
        end
    end

    assign mem_ready = (state == S_ACK);

    // NOTE: FIFO storage is reset on purpose so out_data reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                level[c]  <= '0;
                ovf[c]    <= 1'b0;
                for (int e = 0; e < FIFO_DEPTH; e++) begin
                    fifo_mem[c][e] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) begin
                    fifo_mem[c][wr_ptr[c]] <= mem_wdata[DATA_W-1:0];
                    wr_ptr[c]              <= wr_ptr[c] + PW'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
                end
                level[c] <= level[c] + LW'(push[c]) - LW'(pop[c]);
                if (ovf_set[c]) begin
                    ovf[c] <= 1'b1;
                end else if (ovf_clr[c]) begin
                    ovf[c] <= 1'b0;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign out_valid[c]                  = (level[c] != '0);
        assign out_data[c*DATA_W +: DATA_W]  = fifo_mem[c][rd_ptr[c]];
    end

endmodule

// File: tb/tb_mmio_out_fifo_bank.sv
// Bench for mmio_out_fifo_bank: a non-blocking (dut 0) and a blocking (dut 1) instance
// checked every cycle against a queue-based model of the register/stream behaviour.
module tb_mmio_out_fifo_bank;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          NCH   = 4;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mv   [2];
    logic [31:0] ma   [2];
    logic [31:0] mwd  [2];
    logic [3:0]  ms   [2];
    logic        mr   [2];
    logic [31:0] mrd  [2];
    logic [31:0] od   [2];
    logic [3:0]  ov   [2];
    logic [3:0]  ordy [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmio_out_fifo_bank #(.BASE_ADDR(BASE), .NUM_CH(NCH), .DATA_W(8), .FIFO_DEPTH(DEPTH), .BLOCKING(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .mem_valid(mv[0]), .mem_addr(ma[0]), .mem_wdata(mwd[0]), .mem_wstrb(ms[0]),
        .mem_ready(mr[0]), .mem_rdata(mrd[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0])
    );

    mmio_out_fifo_bank #(.BASE_ADDR(BASE), .NUM_CH(NCH), .DATA_W(8), .FIFO_DEPTH(DEPTH), .BLOCKING(1'b1)) u_dut_bl (
        .clk(clk), .rst(rst), .mem_valid(mv[1]), .mem_addr(ma[1]), .mem_wdata(mwd[1]), .mem_wstrb(ms[1]),
        .mem_ready(mr[1]), .mem_rdata(mrd[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1])
    );

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mq [2][NCH][$];
    bit          movf    [2][NCH];
    bit          m_ack   [2];
    bit          m_rdchk [2];
    logic [31:0] m_rdata [2];

    function automatic logic [31:0] status_of(input int d, input int c);
        int n;
        n = mq[d][c].size();
        return {8'h00, 8'(n), 7'h00, movf[d][c], 6'h00, n == DEPTH, n == 0};
    endfunction

    task automatic model_step(input int d);
        bit          was_ack, wr, st, full, do_push;
        bit          popq [NCH];
        int          c;
        logic [31:0] off;
        logic [7:0]  pv;
        was_ack    = m_ack[d];
        m_ack[d]   = 1'b0;
        m_rdchk[d] = 1'b0;
        do_push    = 1'b0;
        c          = 0;
        pv         = 8'h00;
        for (int k = 0; k < NCH; k++) popq[k] = (mq[d][k].size() != 0) && ordy[d][k];
        off = ma[d] - BASE;
        if (!was_ack && mv[d] && ma[d] >= BASE && ma[d] < BASE + 32'(8 * NCH)) begin
            c    = int'(off / 8);
            st   = (off % 8) >= 4;
            wr   = (ms[d] != 4'h0);
            full = (mq[d][c].size() == DEPTH);
            if (!(d == 1 && wr && !st && ms[d][0] && full && !popq[c])) begin
                m_ack[d] = 1'b1;
                if (!wr) begin
                    m_rdchk[d] = 1'b1;
                    m_rdata[d] = st ? status_of(d, c) : 32'h0;
                end else if (st) begin
                    if (ms[d][1] && mwd[d][8]) movf[d][c] = 1'b0;
                end else if (ms[d][0]) begin
                    if (full && !popq[c]) movf[d][c] = 1'b1;
                    else begin
                        do_push = 1'b1;
                        pv      = mwd[d][7:0];
                    end
                end
            end
        end
        for (int k = 0; k < NCH; k++) if (popq[k]) void'(mq[d][k].pop_front());
        if (do_push) mq[d][c].push_back(pv);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_ack[d]   = 1'b0;
                m_rdchk[d] = 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    mq[d][c].delete();
                    movf[d][c] = 1'b0;
                end
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check("mem_ready", d, 32'(mr[d]), 32'(m_ack[d]));
            if (m_ack[d] && m_rdchk[d]) check("mem_rdata", d, mrd[d], m_rdata[d]);
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("out_valid[%0d]", c), d, 32'(ov[d][c]), 32'(mq[d][c].size() != 0));
                if (mq[d][c].size() != 0)
                    check($sformatf("out_data[%0d]", c), d, 32'(od[d][c*8 +: 8]), 32'(mq[d][c][0]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0]  got  [$];
    logic [7:0]  sent [$];
    logic [31:0] rd0, rd1, addr, wdat;
    logic [3:0]  strb;
    bit          ok0, ok1, rand_done, exp_ok;
    int          lat0, lat1, kind;
    logic [7:0]  wv;

    task automatic bus(input int d, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                       input int budget, output logic [31:0] rd, output bit ok, output int lat);
        mv[d] = 1'b1; ma[d] = a; mwd[d] = w; ms[d] = s;
        ok = 1'b0; rd = 32'h0; lat = 0;
        while (!ok && lat < budget) begin
            @(posedge clk); #1;
            lat++;
            if (mr[d]) begin
                ok = 1'b1;
                rd = mrd[d];
            end
        end
        mv[d] = 1'b0; ms[d] = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] r;
        bit          ok;
        int          l;
        bus(d, a, w, s, 50, r, ok, l);
        check("write ack", d, 32'(ok), 32'd1);
    endtask

    task automatic rd_expect(input string name, input int d, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bit          ok;
        int          l;
        bus(d, a, 32'h0, 4'h0, 50, r, ok, l);
        check({name, " ack"}, d, 32'(ok), 32'd1);
        check(name, d, r, exp);
    endtask

    task automatic drain(input int d, input int c, input int n);
        got.delete();
        ordy[d][c] = 1'b1;
        for (int i = 0; i < n * 8 + 20 && got.size() < n; i++) begin
            if (ov[d][c]) got.push_back(od[d][c*8 +: 8]);
            @(posedge clk); #1;
        end
        ordy[d][c] = 1'b0;
        check("drain count", d, 32'(got.size()), 32'(n));
    endtask

    task automatic expect4(input string name, input int d, input logic [7:0] e0, e1, e2, e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++)
            check($sformatf("%s[%0d]", name, i), d, 32'(i < got.size() ? got[i] : 8'hxx), 32'(e[i]));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; ma[d] = 32'h0; mwd[d] = 32'h0; ms[d] = 4'h0; ordy[d] = 4'h0;
        end
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        for (int d = 0; d < 2; d++) begin
            check("reset mem_ready", d, 32'(mr[d]), 32'd0);
            check("reset mem_rdata", d, mrd[d], 32'h0);
            check("reset out_valid", d, 32'(ov[d]), 32'd0);
            check("reset out_data", d, od[d], 32'h0);
        end

        // Single push to channel 0 and its status.
        bus(0, BASE, 32'h0000_00A5, 4'b0001, 20, rd0, ok0, lat0);
        check("first write ack", 0, 32'(ok0), 32'd1);
        check("first write latency", 0, 32'(lat0), 32'd1);
        check("ch0 out_valid", 0, 32'(ov[0][0]), 32'd1);
        check("ch0 out_data", 0, 32'(od[0][7:0]), 32'h0000_00A5);
        rd_expect("ch0 status", 0, BASE + 32'h4, 32'h0001_0000);

        // Non-blocking overflow on channel 1.
        for (int v = 1; v <= 5; v++) wr(0, BASE + 32'h8, 32'(v), 4'b0001);
        rd_expect("ch1 status full+ovf", 0, BASE + 32'hC, 32'h0004_0102);
        drain(0, 1, 4);
        expect4("ch1 drain", 0, 8'd1, 8'd2, 8'd3, 8'd4);
        rd_expect("ch1 status drained", 0, BASE + 32'hC, 32'h0000_0101);
        wr(0, BASE + 32'hC, 32'h0000_0100, 4'b0010);
        rd_expect("ch1 status cleared", 0, BASE + 32'hC, 32'h0000_0001);

        // Blocking stall on a full channel 0 of dut 1, released by a one-cycle pop.
        for (int v = 1; v <= 4; v++) wr(1, BASE, 32'(v), 4'b0001);
        fork
            bus(1, BASE, 32'h0000_0005, 4'b0001, 20, rd1, ok1, lat1);
            begin
                repeat (4) @(posedge clk);
                #1;
                check("blocking stall ready", 1, 32'(mr[1]), 32'd0);
                ordy[1][0] = 1'b1;
                @(posedge clk); #1;
                ordy[1][0] = 1'b0;
            end
        join
        check("blocking write ack", 1, 32'(ok1), 32'd1);
        check("blocking write latency", 1, 32'(lat1), 32'd5);
        rd_expect("blocking status", 1, BASE + 32'h4, 32'h0004_0002);
        drain(1, 0, 4);
        expect4("blocking drain", 1, 8'd2, 8'd3, 8'd4, 8'd5);

        // Push and pop on a full channel 2 in the same cycle.
        for (int v = 10; v <= 13; v++) wr(0, BASE + 32'h10, 32'(v), 4'b0001);
        ordy[0][2] = 1'b1;
        fork
            bus(0, BASE + 32'h10, 32'd14, 4'b0001, 20, rd0, ok0, lat0);
            begin
                @(posedge clk); #1;
                ordy[0][2] = 1'b0;
            end
        join
        check("full push+pop ack", 0, 32'(ok0), 32'd1);
        check("full push+pop head", 0, 32'(od[0][23:16]), 32'd11);
        rd_expect("full push+pop status", 0, BASE + 32'h14, 32'h0004_0002);
        drain(0, 2, 4);
        expect4("full push+pop drain", 0, 8'd11, 8'd12, 8'd13, 8'd14);

        // Pointer wrap on channel 3 with a continuously ready consumer.
        sent.delete();
        fork
            for (int i = 0; i < 3 * DEPTH; i++) begin
                wv = 8'($urandom);
                sent.push_back(wv);
                bus(0, BASE + 32'h18, {24'h0, wv}, 4'b0001, 20, rd0, ok0, lat0);
            end
            drain(0, 3, 3 * DEPTH);
        join
        for (int i = 0; i < 3 * DEPTH; i++)
            check($sformatf("wrap order[%0d]", i), 0, 32'(i < got.size() ? got[i] : 8'hxx), 32'(sent[i]));

        // Accesses outside the window get no response.
        bus(0, BASE + 32'h20, 32'h0, 4'h0, 6, rd0, ok0, lat0);
        check("out-of-window read ack", 0, 32'(ok0), 32'd0);
        bus(0, 32'h0000_0100, 32'h5A, 4'hF, 6, rd0, ok0, lat0);
        check("out-of-window write ack", 0, 32'(ok0), 32'd0);
        rd_expect("ch0 status unchanged", 0, BASE + 32'h4, 32'h0001_0000);

        // Randomized traffic on both instances with a random consumer.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 240; i++) begin
                    kind = $urandom_range(0, 9);
                    if (kind == 0)      addr = BASE + 32'd32 + 32'($urandom_range(0, 63));
                    else if (kind == 1) addr = BASE - 32'd1 - 32'($urandom_range(0, 63));
                    else addr = BASE + 32'(8 * $urandom_range(0, NCH - 1)) + 32'(4 * $urandom_range(0, 1))
                                + 32'($urandom_range(0, 3));
                    strb   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    wdat   = $urandom;
                    exp_ok = (kind > 1);
                    bus(i % 2, addr, wdat, strb, exp_ok ? 300 : 4, rd0, ok0, lat0);
                    check("random ack", i % 2, 32'(ok0), 32'(exp_ok));
                end
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                @(posedge clk); #1;
                ordy[0] = 4'($urandom);
                ordy[1] = 4'($urandom);
            end
        join
        ordy[0] = 4'h0;
        ordy[1] = 4'h0;
        @(posedge clk); #1;

        // Reset during an ACK cycle.
        mv[0] = 1'b1; ma[0] = BASE; mwd[0] = 32'h33; ms[0] = 4'b0001;
        @(posedge clk); #1;
        check("ack before reset", 0, 32'(mr[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("reset mid-ack ready", 0, 32'(mr[0]), 32'd0);
        check("reset mid-ack out_valid", 0, 32'(ov[0]), 32'd0);
        check("reset mid-ack out_valid", 1, 32'(ov[1]), 32'd0);
        check("reset mid-ack out_data", 0, od[0], 32'h0);
        mv[0] = 1'b0; ms[0] = 4'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rd_expect("post-reset ch0 status", 0, BASE + 32'h4, 32'h0000_0001);
        rd_expect("post-reset ch0 status", 1, BASE + 32'h4, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
